// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: FSM state encoding and default datapath width.
package arith_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// Gate-level one-bit full subtractor: d = a^b^bin, bout = (~a&b) | (~(a^b)&bin).
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic a_x_b;
  logic a_n;
  logic a_x_b_n;
  logic brw_gen;
  logic brw_prop;

  xor_gate u_x_ab  (.a(a),     .b(b),    .y(a_x_b));
  xor_gate u_x_d   (.a(a_x_b), .b(bin),  .y(d));

  // Inverters are XOR gates tied to 1 so the cell uses only the gate library.
  xor_gate u_inv_a (.a(a),     .b(1'b1), .y(a_n));
  xor_gate u_inv_p (.a(a_x_b), .b(1'b1), .y(a_x_b_n));

  and_gate u_a_gen (.a(a_n),     .b(b),   .y(brw_gen));
  and_gate u_a_prp (.a(a_x_b_n), .b(bin), .y(brw_prop));
  or_gate  u_o_bo  (.a(brw_gen), .b(brw_prop), .y(bout));

endmodule

// File: rtl/logic_gates.sv
// Two-input gate primitives used by the structural arithmetic cells.
module xor_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a ^ b;
endmodule

module and_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a & b;
endmodule

module or_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a | b;
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock through a single full-subtractor cell.
//   state    | meaning
//   ST_IDLE  | waiting for start; outputs hold the last result
//   ST_SHIFT | one operand bit per cycle, WIDTH cycles
//   ST_DONE  | one-cycle done pulse; start here chains the next operation
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_nxt;
  logic [CW-1:0]    bit_cnt;
  logic             borrow;
  logic             load;
  logic             shift_en;
  logic             last_bit;
  logic             fs_d;
  logic             fs_bo;

  full_subtractor u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (borrow),
    .d    (fs_d),
    .bout (fs_bo)
  );

  assign last_bit = (bit_cnt == LAST_BIT);
  assign res_nxt  = {fs_d, res_sr[WIDTH-1:1]};

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift_en  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift_en = 1'b1;
        if (last_bit) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = ST_SHIFT;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      bit_cnt <= '0;
      borrow  <= 1'b0;
    end else if (load) begin
      a_sr    <= a;
      b_sr    <= b;
      res_sr  <= '0;
      bit_cnt <= '0;
      borrow  <= 1'b0;
    end else if (shift_en) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_nxt;
      borrow <= fs_bo;
      if (!last_bit) begin
        bit_cnt <= bit_cnt + CW'(1);
      end
    end
  end

  // Results are written on the edge that enters DONE so they are valid with the pulse.
  // The borrow into the MSB is still in the flop at that edge, so ovf uses it directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      diff <= '0;
      bout <= 1'b0;
      ovf  <= 1'b0;
    end else if (shift_en && last_bit) begin
      diff <= res_nxt;
      bout <= fs_bo;
      ovf  <= borrow ^ fs_bo;
    end
  end

  assign busy = (state == ST_SHIFT);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor with a cycle-level behavioural model and per-cycle compare.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  // Model: remaining busy cycles plus the operation in flight, results from plain arithmetic.
  int           m_left = 0;
  bit           m_done = 1'b0;
  logic [W-1:0] m_a = '0;
  logic [W-1:0] m_b = '0;
  logic [W-1:0] m_diff = '0;
  bit           m_bout = 1'b0;
  bit           m_ovf = 1'b0;

  function automatic int to_signed(input logic [W-1:0] v);
    return (v >= 8'h80) ? int'(v) - 256 : int'(v);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0;
      m_done = 1'b0;
      m_diff = '0;
      m_bout = 1'b0;
      m_ovf  = 1'b0;
    end else if (m_left == 1) begin
      int sd;
      m_left = 0;
      m_done = 1'b1;
      m_diff = W'(int'(m_a) - int'(m_b));
      m_bout = (m_a < m_b);
      sd     = to_signed(m_a) - to_signed(m_b);
      m_ovf  = (sd > 127) || (sd < -128);
    end else if (m_left > 1) begin
      m_left = m_left - 1;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (start) begin
        m_a    = a;
        m_b    = b;
        m_left = W;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_vec = n_vec + 1;
      if (busy !== (m_left > 0) || done !== m_done || diff !== m_diff ||
          bout !== m_bout || ovf !== m_ovf) begin
        n_bad = n_bad + 1;
        $display("FAIL cycle_compare t=%0t: dut busy=%b done=%b diff=%h bout=%b ovf=%b, model busy=%b done=%b diff=%h bout=%b ovf=%b",
                 $time, busy, done, diff, bout, ovf, (m_left > 0), m_done, m_diff, m_bout, m_ovf);
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Drive start with operands for one edge; returns in cycle 1 of the operation.
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv);
    a = av;
    b = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called in cycle 1; returns in the done cycle with its cycle number (0 on timeout).
  task automatic wait_done(input string name, output int cyc);
    cyc = 1;
    while (!done && cyc < 30) begin
      tick();
      cyc = cyc + 1;
    end
    if (!done) begin
      cyc = 0;
      n_vec = n_vec + 1;
      n_bad = n_bad + 1;
      $display("FAIL %s_timeout: done never seen, expected within 30 cycles", name);
    end
  endtask

  task automatic check_result(input string name, input logic [W-1:0] ed, input bit eb, input bit eo);
    check({name, "_diff"}, int'(diff), int'(ed));
    check({name, "_bout"}, int'(bout), int'(eb));
    check({name, "_ovf"},  int'(ovf),  int'(eo));
    check({name, "_model"}, int'({m_diff, m_bout, m_ovf}), int'({ed, eb, eo}));
  endtask

  initial begin
    int cyc;

    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("reset_state", int'({busy, done, diff, bout, ovf}), 0);

    // Basic operation with latency check.
    start_op(8'h5A, 8'h23);
    check("busy_cycle1", int'(busy), 1);
    wait_done("op1", cyc);
    check("op1_latency", cyc, 9);
    check_result("op1", 8'h37, 1'b0, 1'b0);

    // Back-to-back: start during the done cycle.
    tick();
    start_op(8'h00, 8'h01);
    wait_done("op2", cyc);
    check_result("op2", 8'hFF, 1'b1, 1'b0);
    a = 8'h80;
    b = 8'h01;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b_busy", int'(busy), 1);
    wait_done("op3", cyc);
    check("op3_latency", cyc, 9);
    check_result("op3", 8'h7F, 1'b0, 1'b1);

    tick();
    tick();
    start_op(8'h7F, 8'hFF);
    wait_done("op4", cyc);
    check_result("op4", 8'h80, 1'b1, 1'b1);
    tick();
    start_op(8'h33, 8'h33);
    wait_done("op5", cyc);
    check_result("op5", 8'h00, 1'b0, 1'b0);

    // Start pulse mid-operation is ignored; outputs hold afterwards.
    tick();
    tick();
    start_op(8'h9C, 8'h0F);
    tick();
    tick();
    a = 8'h01;
    b = 8'h02;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 4;
    while (!done && cyc < 30) begin
      tick();
      cyc = cyc + 1;
    end
    check("ignored_start_latency", cyc, 9);
    check_result("op6", 8'h8D, 1'b0, 1'b0);
    repeat (4) tick();
    check("hold_after_done", int'({busy, done, diff, bout, ovf}), int'({1'b0, 1'b0, 8'h8D, 1'b0, 1'b0}));

    // Start held high across SHIFT and the done cycle: second op uses operands at done.
    a = 8'h44;
    b = 8'h11;
    start = 1'b1;
    tick();
    a = 8'h10;
    b = 8'h20;
    wait_done("op7", cyc);
    check_result("op7", 8'h33, 1'b0, 1'b0);
    tick();
    start = 1'b0;
    wait_done("op8", cyc);
    check("op8_latency", cyc, 9);
    check_result("op8", 8'hF0, 1'b1, 1'b0);

    // Reset at cycle 4 aborts the operation without a done pulse.
    tick();
    tick();
    start_op(8'h5A, 8'h23);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("reset_abort", int'({busy, done, diff, bout, ovf}), 0);
    cyc = 0;
    repeat (12) begin
      tick();
      if (done) cyc = cyc + 1;
    end
    check("no_done_after_abort", cyc, 0);
    start_op(8'h5A, 8'h23);
    wait_done("op9", cyc);
    check("op9_latency", cyc, 9);
    check_result("op9", 8'h37, 1'b0, 1'b0);

    tick();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
